// File: rtl/dual_edge_event_encoder.sv
// dual_edge_event_encoder: turns single-cycle event requests into one toggle
// each on line_out. The toggles are spaced by at least HOLD_CYCLES edges, and
// any backlog waits in a saturating pending counter.
module dual_edge_event_encoder #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 4,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_in,
  input  logic             clr_ovf,
  output logic             line_out,
  output logic             edge_strobe,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam bit                MULTI     = (HOLD_CYCLES > 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              line_q, line_d;
  logic              strobe_q, strobe_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              emit_c;

  // State and output registers; reset returns the line to its idle level at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      line_q   <= INIT_LEVEL;
      strobe_q <= 1'b0;
      pend_q   <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      strobe_q <= strobe_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: emit directly from IDLE, queue during HOLD, emit from the queue in DRAIN.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    strobe_d = 1'b0;
    pend_d   = pend_q;
    hold_d   = hold_q;
    ovf_d    = ovf_q & ~clr_ovf;
    emit_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ev_in) begin
          emit_c  = 1'b1;
          state_d = MULTI ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (ev_in) begin
          // A full counter drops the event; a drop takes priority over clr_ovf.
          if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
          end else begin
            pend_d = pend_q + CNT_W'(1);
          end
        end
        if (hold_d == '0) begin
          state_d = (pend_d != '0) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        // The emit takes one event from the queue, and an event arriving on the same edge is added.
        emit_c = 1'b1;
        pend_d = pend_q - CNT_W'(1) + CNT_W'(ev_in);
        if (MULTI) begin
          state_d = S_HOLD;
        end else begin
          state_d = (pend_d != '0) ? S_DRAIN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit_c) begin
      line_d   = ~line_q;
      strobe_d = 1'b1;
      hold_d   = HOLD_LOAD;
    end

    busy_d = (pend_d != '0) || (hold_d != '0);
  end

  assign line_out    = line_q;
  assign edge_strobe = strobe_q;
  assign pending     = pend_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_dual_edge_event_encoder.sv
// Directed bench for dual_edge_event_encoder. It uses three instances:
// HOLD_CYCLES=2 with CNT_W=4, HOLD_CYCLES=4 with CNT_W=2, and HOLD_CYCLES=1.
module tb_dual_edge_event_encoder;

  logic clk;
  logic rst;

  logic       ev2, clr2, line2, stb2, busy2, ovf2;
  logic [3:0] pend2;
  logic       ev4, clr4, line4, stb4, busy4, ovf4;
  logic [1:0] pend4;
  logic       ev1, clr1, line1, stb1, busy1, ovf1;
  logic [3:0] pend1;

  int n_vec  = 0;
  int n_fail = 0;

  dual_edge_event_encoder #(.HOLD_CYCLES(2), .CNT_W(4), .INIT_LEVEL(1'b0)) u_h2 (
    .clk(clk), .rst(rst), .ev_in(ev2), .clr_ovf(clr2), .line_out(line2),
    .edge_strobe(stb2), .pending(pend2), .busy(busy2), .overflow(ovf2));

  dual_edge_event_encoder #(.HOLD_CYCLES(4), .CNT_W(2), .INIT_LEVEL(1'b0)) u_h4 (
    .clk(clk), .rst(rst), .ev_in(ev4), .clr_ovf(clr4), .line_out(line4),
    .edge_strobe(stb4), .pending(pend4), .busy(busy4), .overflow(ovf4));

  dual_edge_event_encoder #(.HOLD_CYCLES(1), .CNT_W(4), .INIT_LEVEL(1'b0)) u_h1 (
    .clk(clk), .rst(rst), .ev_in(ev1), .clr_ovf(clr1), .line_out(line1),
    .edge_strobe(stb1), .pending(pend1), .busy(busy1), .overflow(ovf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Far-end dual-edge detector model: one pulse per level change seen at posedge.
  int   det2 = 0;
  logic prev2;
  always @(posedge clk) begin
    if (line2 !== prev2) det2 <= det2 + 1;
    prev2 <= line2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges; called at posedge+1.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  int bl[6] = '{1, 1, 0, 0, 1, 1};
  int bp[6] = '{0, 1, 1, 1, 0, 0};
  int bs[6] = '{1, 0, 1, 0, 1, 0};
  int op[6] = '{0, 1, 2, 3, 3, 3};
  int ol[6] = '{1, 1, 1, 1, 0, 0};
  int oo[6] = '{0, 0, 0, 0, 0, 1};
  int base;

  initial begin
    rst = 1'b1;
    ev2 = 1'b0; clr2 = 1'b0;
    ev4 = 1'b0; clr4 = 1'b0;
    ev1 = 1'b0; clr1 = 1'b0;

    // Reset values before any clock edge
    #3;
    check("rst_line",   32'(line2), 32'd0);
    check("rst_strobe", 32'(stb2),  32'd0);
    check("rst_pend",   32'(pend2), 32'd0);
    check("rst_busy",   32'(busy2), 32'd0);
    check("rst_ovf",    32'(ovf2),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single event, HOLD_CYCLES=2
    ev2 = 1'b1; tick(); ev2 = 1'b0;
    check("single_e1_line",   32'(line2), 32'd1);
    check("single_e1_strobe", 32'(stb2),  32'd1);
    check("single_e1_busy",   32'(busy2), 32'd1);
    tick();
    check("single_e2_busy",   32'(busy2), 32'd0);
    check("single_e2_strobe", 32'(stb2),  32'd0);

    // Burst of three, HOLD_CYCLES=2
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      ev2 = (i < 3);
      tick();
      check($sformatf("burst_e%0d_line", i + 1),   32'(line2), 32'(bl[i]));
      check($sformatf("burst_e%0d_pend", i + 1),   32'(pend2), 32'(bp[i]));
      check($sformatf("burst_e%0d_strobe", i + 1), 32'(stb2),  32'(bs[i]));
    end
    ev2 = 1'b0;
    check("burst_e6_busy", 32'(busy2), 32'd0);

    // Saturation and overflow, CNT_W=2, HOLD_CYCLES=4
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      ev4 = 1'b1;
      tick();
      check($sformatf("ovf_e%0d_pend", i + 1), 32'(pend4), 32'(op[i]));
      check($sformatf("ovf_e%0d_line", i + 1), 32'(line4), 32'(ol[i]));
      check($sformatf("ovf_e%0d_flag", i + 1), 32'(ovf4),  32'(oo[i]));
    end
    ev4 = 1'b0; clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    check("ovf_e7_cleared", 32'(ovf4), 32'd0);

    // Asynchronous reset in the middle of a backlog
    pulse_reset();
    ev4 = 1'b1;
    tick(); tick(); tick();
    ev4 = 1'b0;
    check("midrst_pre_line", 32'(line4), 32'd1);
    check("midrst_pre_pend", 32'(pend4), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_line",   32'(line4), 32'd0);
    check("midrst_pend",   32'(pend4), 32'd0);
    check("midrst_busy",   32'(busy4), 32'd0);
    check("midrst_strobe", 32'(stb4),  32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("midrst_quiet%0d_line", i), 32'(line4), 32'd0);
    end
    check("midrst_quiet_strobe", 32'(stb4), 32'd0);

    // HOLD_CYCLES=1: ev_in held high toggles the line every cycle
    for (int i = 0; i < 4; i++) begin
      ev1 = 1'b1;
      tick();
      check($sformatf("h1_e%0d_line", i + 1),   32'(line1), 32'((i % 2) == 0));
      check($sformatf("h1_e%0d_strobe", i + 1), 32'(stb1),  32'd1);
      check($sformatf("h1_e%0d_pend", i + 1),   32'(pend1), 32'd0);
    end
    ev1 = 1'b0;
    tick();
    check("h1_idle_strobe", 32'(stb1),  32'd0);
    check("h1_idle_busy",   32'(busy1), 32'd0);
    check("h1_idle_line",   32'(line1), 32'd0);

    // Conservation: 10 events at 3-cycle spacing give 10 detector pulses
    base = det2;
    for (int i = 0; i < 10; i++) begin
      ev2 = 1'b1; tick();
      ev2 = 1'b0; tick(); tick();
    end
    tick(); tick();
    check("cons_pulses", 32'(det2 - base), 32'd10);
    check("cons_pend",   32'(pend2),       32'd0);
    check("cons_ovf",    32'(ovf2),        32'd0);
    check("cons_busy",   32'(busy2),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
